// File: rtl/q_reduce_pkg.sv
// q_reduce_pkg: shared constants, state type and the subtract-with-borrow
// helper for the word-serial q reducer.
//   W    : word width in bits
//   NW   : words per operand (top word holds 3 significant bits of q)
//   SELW : width of the q ROM select bus
package q_reduce_pkg;

  localparam int unsigned W    = 59;
  localparam int unsigned NW   = 4;
  localparam int unsigned SELW = 6;
  localparam int unsigned IW   = $clog2(NW);     // buffer index width
  localparam int unsigned CW   = $clog2(NW) + 1; // counter width, holds NW

  // IDLE is folded into LOAD: LOAD with primed=0 behaves as IDLE.
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Returns {bout, diff} of a - b - bin evaluated at W+1 bits; the top bit
  // is set exactly when a < b + bin.
  function automatic logic [W:0] sub_borrow(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         bin);
    sub_borrow = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

endpackage

// File: rtl/q_word_subber.sv
// q_word_subber: one combinational W-bit subtract-with-borrow slice.
//   i_a, i_b : minuend / subtrahend words
//   i_bin    : borrow in
//   o_diff   : (i_a - i_b - i_bin) mod 2^W
//   o_bout   : borrow out
module q_word_subber
  import q_reduce_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_diff,
  output logic         o_bout
);

  logic [W:0] w_res;

  assign w_res  = sub_borrow(i_a, i_b, i_bin);
  assign o_diff = w_res[W-1:0];
  assign o_bout = w_res[W];

endmodule

// File: rtl/q_word_reducer.sv
// q_word_reducer: word-serial final reduction x mod q for x < 2q.
// Accepts NW little-endian words of x, subtracts the matching q words
// fetched from an external registered ROM, buffers x and x-q, then streams
// whichever one is the reduced result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   q_sel / q_word      : ROM index out, registered ROM data in (1 cycle)
//   in_valid/ready/data : input word stream, LS word first
//   out_valid/ready/data: output word stream, LS word first
//   out_last            : marks the final output word
//   reduced             : 1 when q was subtracted, stable over the burst
module q_word_reducer
  import q_reduce_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic [SELW-1:0] q_sel,
  input  logic [W-1:0]    q_word,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic            reduced
);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_k;
  logic           r_borrow;
  logic           r_primed;
  logic           r_reduced;
  logic [W-1:0]   r_xbuf [NW];
  logic [W-1:0]   r_dbuf [NW];

  logic           w_accept;
  logic           w_bin;
  logic [W-1:0]   w_diff;
  logic           w_bout;
  logic [CW-1:0]  w_sel_cnt;
  logic [IW-1:0]  w_widx;
  logic [IW-1:0]  w_ridx;

  assign in_ready = r_primed && (r_state == LOAD);
  assign w_accept = in_valid && in_ready;
  assign w_bin    = (r_cnt == '0) ? 1'b0 : r_borrow;
  assign w_widx   = r_cnt[IW-1:0];
  assign w_ridx   = r_k[IW-1:0];

  // Look one word ahead on accept so the registered ROM output always
  // lines up with cnt; during OUT park on word 0 for the next operand.
  assign w_sel_cnt = w_accept ? (r_cnt + CW'(1)) : r_cnt;
  assign q_sel     = (r_state == OUT) ? '0 : SELW'(w_sel_cnt);

  q_word_subber u_subber (
    .i_a    (in_data),
    .i_b    (q_word),
    .i_bin  (w_bin),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_cnt     <= '0;
      r_k       <= '0;
      r_borrow  <= 1'b0;
      r_primed  <= 1'b0;
      r_reduced <= 1'b0;
      for (int unsigned i = 0; i < NW; i++) begin
        r_xbuf[i] <= '0;
        r_dbuf[i] <= '0;
      end
    end else begin
      r_primed <= 1'b1;
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_xbuf[w_widx] <= in_data;
            r_dbuf[w_widx] <= w_diff;
            r_borrow       <= w_bout;
            r_cnt          <= r_cnt + CW'(1);
            if (r_cnt == CW'(NW - 1)) begin
              r_state   <= OUT;
              r_k       <= '0;
              r_reduced <= ~w_bout;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (r_k == CW'(NW - 1)) begin
              r_state  <= LOAD;
              r_cnt    <= '0;
              r_borrow <= 1'b0;
              r_k      <= '0;
            end else begin
              r_k <= r_k + CW'(1);
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign out_valid = (r_state == OUT);
  assign out_last  = out_valid && (r_k == CW'(NW - 1));
  assign reduced   = r_reduced;
  assign out_data  = r_reduced ? r_dbuf[w_ridx] : r_xbuf[w_ridx];

endmodule

// File: tb/tb_q_word_reducer.sv
// Scoreboard bench for q_word_reducer with a registered q ROM model.
module tb_q_word_reducer;
  import q_reduce_pkg::*;

  localparam logic [W-1:0] Q0 = 59'd393394748469346305;
  localparam logic [W-1:0] Q1 = 59'd417767552804925659;
  localparam logic [W-1:0] Q2 = 59'd506224710668493737;
  localparam logic [W-1:0] Q3 = 59'd7;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SELW-1:0] q_sel;
  logic [W-1:0]    q_word;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic            reduced;

  int errors = 0;
  int checks = 0;
  bit toggle_ready = 1'b0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         red;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Registered q ROM: data for q_sel appears one cycle later.
  always_ff @(posedge clk) begin
    case (q_sel)
      6'd0:    q_word <= Q0;
      6'd1:    q_word <= Q1;
      6'd2:    q_word <= Q2;
      6'd3:    q_word <= Q3;
      default: q_word <= '0;
    endcase
  end

  q_word_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_sel     (q_sel),
    .q_word    (q_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .reduced   (reduced)
  );

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard and
  // checks that input is blocked and the ROM is parked on word 0 in OUT.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_in_out", {58'd0, in_ready}, '0);
      check("q_sel_in_out", W'(q_sel), '0);
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", {58'd0, out_last}, {58'd0, e.last});
          check("reduced", {58'd0, reduced}, {58'd0, e.red});
        end
      end
    end
  end

  // out_ready pattern driver: 1 normally, alternating 1010.. when enabled.
  always @(posedge clk) begin
    #1;
    if (toggle_ready) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  task automatic send_word(input logic [W-1:0] w, output bit ok);
    int guard = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = (guard < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_op(input logic [W-1:0] x0, input logic [W-1:0] x1,
                         input logic [W-1:0] x2, input logic [W-1:0] x3,
                         input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input logic [W-1:0] e3,
                         input logic red, input bit gap, input bit keep_valid);
    bit ok;
    logic [W-1:0] xs [4];
    logic [W-1:0] es [4];
    xs = '{x0, x1, x2, x3};
    es = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) sb.push_back('{es[i], (i == 3), red});
    for (int i = 0; i < 4; i++) begin
      send_word(xs[i], ok);
      if (gap && i == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    // First output word is presented the cycle after the final accept.
    check("out_valid_latency", {58'd0, out_valid}, {58'd0, 1'b1});
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    bit ok;
    // Reset state
    #12;
    check("rst_in_ready", {58'd0, in_ready}, '0);
    check("rst_out_valid", {58'd0, out_valid}, '0);
    check("rst_out_last", {58'd0, out_last}, '0);
    check("rst_reduced", {58'd0, reduced}, '0);
    check("rst_out_data", out_data, '0);
    check("rst_q_sel", W'(q_sel), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // x = 0, with an in_valid gap
    send_op('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    drain();
    // x = q
    send_op(Q0, Q1, Q2, Q3, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drain();
    // x = q-1 passes through
    send_op(Q0 - 1, Q1, Q2, Q3, Q0 - 1, Q1, Q2, Q3, 1'b0, 1'b0, 1'b0);
    drain();
    // x = q+5
    send_op(Q0 + 5, Q1, Q2, Q3, 59'd5, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drain();

    // Back-to-back with toggling out_ready, in_valid held high
    toggle_ready = 1'b1;
    send_op(Q0 + 5, Q1, Q2, Q3, 59'd5, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    send_op(Q0 - 1, Q1, Q2, Q3, Q0 - 1, Q1, Q2, Q3, 1'b0, 1'b0, 1'b1);
    send_op(Q0, Q1, Q2, Q3, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    drain();
    in_valid = 1'b0;
    toggle_ready = 1'b0;
    @(posedge clk); #1;
    check("q_sel_next_load", W'(q_sel), '0);
    check("in_ready_next_load", {58'd0, in_ready}, {58'd0, 1'b1});

    // Reset pulse after the second input word
    send_word(ALL1 >> 1, ok);
    send_word(59'd12345, ok);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {58'd0, in_ready}, '0);
    check("mid_rst_out_valid", {58'd0, out_valid}, '0);
    check("mid_rst_out_last", {58'd0, out_last}, '0);
    check("mid_rst_reduced", {58'd0, reduced}, '0);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_q_sel", W'(q_sel), '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_op(Q0 + 5, Q1, Q2, Q3, 59'd5, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_word_reducer.md
Name: q_word_reducer

Overview:
- Word-serial final modular reduction against the 180-bit modulus q. Computes x mod q for an input x < 2q.
- x arrives as 4 little-endian 59-bit words. The block fetches the matching q words from the external registered q-constant ROM, computing x − q word by word with borrow propagation.
- It buffers both x and x − q, then streams out whichever is correct.
- Sits between the CRT/lift datapath output and the result memory writer; it is the reading side of the q-word ROM.

Parameters:
- W, 59, word width in bits.
- NW, 4, words per operand (top word holds 3 significant bits).
- SELW, 6, width of the ROM select bus.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- q_sel  out  SELW  word index driven to the q ROM. ROM returns data one cycle later.
- q_word  in  W  registered ROM data for the q_sel of the previous cycle.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  W  input word, least significant word first.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  W  reduced result word, least significant first.
- out_last  out  1  high with the 4th output word.
- reduced  out  1  1 if q was subtracted; held stable for the whole output burst.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE, cnt=0, borrow=0, primed=0.
  - in_ready=0, out_valid=0, out_last=0, reduced=0, out_data=0.
  - q_sel=0; buffers are cleared to 0.
- q_sel is combinational: q_sel = cnt+1 when a word is accepted this cycle (in_valid & in_ready), otherwise cnt. This guarantees q_word = q[cnt] on every cycle after priming.
- primed is set one cycle after reset release and never cleared except by reset. in_ready requires primed.
- IDLE / LOAD (one state):
  - in_ready = primed & (state==LOAD).
  - On accept at index cnt:
    - xbuf[cnt] ← in_data.
    - dbuf[cnt] ← (in_data − q_word − borrow) mod 2^W.
    - borrow ← (in_data < q_word + borrow), compared at W+1 bits.
    - cnt ← cnt+1.
  - borrow is taken as 0 for cnt=0.
  - Throughput is 1 word/cycle; in_valid gaps are allowed.
  - On accepting the word at cnt=NW−1: state ← OUT, k ← 0, reduced ← ~borrow_next.
- OUT:
  - out_valid=1 and in_ready=0.
  - out_data = reduced ? dbuf[k] : xbuf[k].
  - out_last = (k==NW−1).
  - On out_ready, k ← k+1. On the handshake with k==NW−1: state ← LOAD, cnt ← 0, borrow ← 0.
  - out_valid rises the cycle after the last input accept. Minimum latency is 1 cycle; out_valid is held under backpressure.
- q_sel during OUT is 0, so q[0] is ready for the next operand with no bubble.
- x ≥ 2q or nonzero bits above bit 2 of word 3: the result is unspecified, but the block must still return to LOAD after 4 output words.
- x == q gives 0. x == q−1 passes x through unchanged.
- A reset asserted mid-LOAD or mid-OUT aborts the operation. No partial output appears after release.
- cnt and k wrap only by explicit clear, never by overflow.

Decomposition:
- Package q_reduce_pkg holds:
  - W, NW, SELW;
  - the state enum {LOAD, OUT} (IDLE is merged into LOAD with primed=0);
  - function sub_borrow(a,b,bin) → {bout, diff}.
- Optional sub-module q_word_subber: one combinational W-bit subtract-with-borrow slice.
- The q ROM stays external; the bench instantiates the existing 180-bit q ROM on q_sel/q_word.

Test Plan:
- x = 0 (all words 0) → out words 0,0,0,0; reduced=0; out_last on word 4.
- x = q (393394748469346305, 417767552804925659, 506224710668493737, 7) → out 0,0,0,0; reduced=1.
- x = q−1 (393394748469346304, 417767552804925659, 506224710668493737, 7) → same words out; reduced=0.
- x = q+5 (393394748469346310, …, 7) → out 5,0,0,0; reduced=1.
- Back-to-back: 3 operands with in_valid constant high and out_ready toggled 1010… → correct results, no lost words, in_ready=0 throughout OUT, q_sel=0 at each new LOAD.
- Reset pulse after the 2nd input word → all outputs 0 asynchronously. A fresh x = q+5 afterwards → 5,0,0,0.
